// File: rtl/spi_flash_word_reader.sv
// spi_flash_word_reader: read-only SPI flash port for the SOC data bus.
// A one-cycle rstrb starts one SPI READ transaction: opcode, 24-bit byte
// address, then 32 data bits. The bytes are assembled little-endian into rdata.
// SPI mode 0, with the SPI clock running at clk/2.
// Compile-time option: define SPIFLASH_FAST_READ_EN to use opcode 0x0B. This
// inserts 8 dummy bits between the address and the data.
//
// state | meaning
// IDLE  | CS_N high, waiting for rstrb or a pending request
// SEND  | shifting out opcode + address (32 bits)
// DUMMY | 8 dummy bits, MOSI low (fast-read build only)
// RECV  | shifting in 32 data bits, MOSI low
// HOLD  | one cycle with CS_N high; a strobe here is queued as pending
module spi_flash_word_reader #(
    parameter logic [23:0] ADDR_OFFSET = 24'h100000,
    parameter logic [7:0]  CMD_READ    = 8'h03
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [19:0] word_address,
    input  logic        rstrb,
    output logic [31:0] rdata,
    output logic        rbusy,
    output logic        CLK,
    output logic        CS_N,
    output logic        MOSI,
    input  logic        MISO
);

`ifdef SPIFLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE = 8'h0B;
    typedef enum logic [2:0] {IDLE, SEND, DUMMY, RECV, HOLD} state_t;
`else
    localparam logic [7:0] OPCODE = CMD_READ;
    typedef enum logic [2:0] {IDLE, SEND, RECV, HOLD} state_t;
`endif

    state_t      state;
    logic        phase;      // 0: SPI clock low phase, 1: high phase
    logic [4:0]  bit_cnt;    // bits remaining in the current state, minus one
    logic [31:0] shift_out;
    logic [31:0] shift_in;
    logic        pending;
    logic [23:0] addr24;
    logic [31:0] rx_word;

    // The byte address wraps modulo 2^24; no overflow is reported.
    assign addr24  = ADDR_OFFSET + {2'b00, word_address, 2'b00};
    assign rx_word = {shift_in[30:0], MISO};

    // Transaction sequencer; every output is registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            phase     <= 1'b0;
            bit_cnt   <= 5'd0;
            shift_out <= 32'd0;
            shift_in  <= 32'd0;
            pending   <= 1'b0;
            rdata     <= 32'd0;
            rbusy     <= 1'b0;
            CLK       <= 1'b0;
            CS_N      <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending || rstrb) begin
                        // A pending request already latched its address in HOLD.
                        if (!pending) begin
                            shift_out <= {OPCODE, addr24};
                            MOSI      <= OPCODE[7];
                        end else begin
                            MOSI      <= shift_out[31];
                        end
                        pending <= 1'b0;
                        CS_N    <= 1'b0;
                        CLK     <= 1'b0;
                        rbusy   <= 1'b1;
                        phase   <= 1'b0;
                        bit_cnt <= 5'd31;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (!phase) begin
                        CLK   <= 1'b1;
                        phase <= 1'b1;
                    end else begin
                        CLK       <= 1'b0;
                        phase     <= 1'b0;
                        shift_out <= shift_out << 1;
                        if (bit_cnt == 5'd0) begin
                            MOSI <= 1'b0;
`ifdef SPIFLASH_FAST_READ_EN
                            bit_cnt <= 5'd7;
                            state   <= DUMMY;
`else
                            bit_cnt <= 5'd31;
                            state   <= RECV;
`endif
                        end else begin
                            MOSI    <= shift_out[30];
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
`ifdef SPIFLASH_FAST_READ_EN
                DUMMY: begin
                    if (!phase) begin
                        CLK   <= 1'b1;
                        phase <= 1'b1;
                    end else begin
                        CLK   <= 1'b0;
                        phase <= 1'b0;
                        if (bit_cnt == 5'd0) begin
                            bit_cnt <= 5'd31;
                            state   <= RECV;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
`endif
                RECV: begin
                    if (!phase) begin
                        CLK   <= 1'b1;
                        phase <= 1'b1;
                    end else begin
                        CLK      <= 1'b0;
                        phase    <= 1'b0;
                        shift_in <= rx_word;
                        if (bit_cnt == 5'd0) begin
                            // The first byte received is the lowest address; it goes to rdata[7:0].
                            rdata <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
                            rbusy <= 1'b0;
                            CS_N  <= 1'b1;
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                HOLD: begin
                    // Queue a strobe seen here so that CS_N stays high for the following IDLE cycle as well.
                    if (rstrb) begin
                        pending   <= 1'b1;
                        rbusy     <= 1'b1;
                        shift_out <= {OPCODE, addr24};
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_word_reader.sv
// Directed bench for spi_flash_word_reader with a behavioural mode-0 flash model.
module tb_spi_flash_word_reader;

`ifdef SPIFLASH_FAST_READ_EN
    localparam logic [7:0] EXP_OP  = 8'h0B;
    localparam int         EXP_LAT = 144;
    localparam int         DUM     = 8;
`else
    localparam logic [7:0] EXP_OP  = 8'h03;
    localparam int         EXP_LAT = 128;
    localparam int         DUM     = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [19:0] word_address = 20'd0;
    logic        rstrb = 1'b0;
    logic [31:0] rdata;
    logic        rbusy;
    logic        CLK, CS_N, MOSI;
    logic        MISO = 1'b0;

    logic [19:0] word_address2 = 20'd0;
    logic        rstrb2 = 1'b0;
    logic [31:0] rdata2;
    logic        rbusy2;
    logic        CLK2, CS_N2, MOSI2;
    logic        MISO2 = 1'b1;

    int errors = 0;
    int checks = 0;

    spi_flash_word_reader u_dut (
        .clk(clk), .resetn(resetn), .word_address(word_address), .rstrb(rstrb),
        .rdata(rdata), .rbusy(rbusy), .CLK(CLK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO)
    );

    spi_flash_word_reader #(.ADDR_OFFSET(24'hFFFFFC)) u_wrap (
        .clk(clk), .resetn(resetn), .word_address(word_address2), .rstrb(rstrb2),
        .rdata(rdata2), .rbusy(rbusy2), .CLK(CLK2), .CS_N(CS_N2), .MOSI(MOSI2), .MISO(MISO2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h100000: flash_byte = 8'h11;
            24'h100001: flash_byte = 8'h22;
            24'h100002: flash_byte = 8'h33;
            24'h100003: flash_byte = 8'h44;
            24'h100004: flash_byte = 8'h55;
            24'h100005: flash_byte = 8'h66;
            24'h100006: flash_byte = 8'h77;
            24'h100007: flash_byte = 8'h88;
            24'h4FFFFC: flash_byte = 8'hA1;
            24'h4FFFFD: flash_byte = 8'hB2;
            24'h4FFFFE: flash_byte = 8'hC3;
            24'h4FFFFF: flash_byte = 8'hD4;
            default:    flash_byte = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Flash model: it samples MOSI on the rising SPI clock and drives MISO just after the falling SPI clock.
    int          bitn = 0;
    logic [31:0] cmd_cap = 32'd0;
    logic        extra_nz = 1'b0;
    int          k_idx;
    logic [7:0]  cur_byte;

    always @(negedge CS_N) begin
        bitn     = 0;
        extra_nz = 1'b0;
    end

    always @(posedge CLK) begin
        if (!CS_N) begin
            if (bitn < 32) cmd_cap = {cmd_cap[30:0], MOSI};
            else if (MOSI) extra_nz = 1'b1;
            bitn++;
        end
    end

    always @(negedge CLK) begin
        if (!CS_N) begin
            #1;
            k_idx = bitn - 32 - DUM;
            if (k_idx >= 0 && k_idx < 32) begin
                cur_byte = flash_byte(cmd_cap[23:0] + 24'(k_idx / 8));
                MISO = cur_byte[7 - (k_idx % 8)];
            end
        end
    end

    // Command capture for the wrap instance.
    int          bitn2 = 0;
    logic [31:0] cmd_cap2 = 32'd0;

    always @(negedge CS_N2) bitn2 = 0;

    always @(posedge CLK2) begin
        if (!CS_N2) begin
            if (bitn2 < 32) cmd_cap2 = {cmd_cap2[30:0], MOSI2};
            bitn2++;
        end
    end

    // Strobes one read, then counts the cycles in which rbusy is high. An optional second strobe is injected mid-transaction.
    task automatic do_read(input logic [19:0] wa, input int inject_at, output int n);
        word_address = wa;
        rstrb = 1'b1;
        @(posedge clk); #1;
        rstrb = 1'b0;
        n = 0;
        while (rbusy && n < 1000) begin
            n++;
            if (n == inject_at) begin
                rstrb = 1'b1;
                word_address = 20'd2;
            end else begin
                rstrb = 1'b0;
            end
            @(posedge clk); #1;
        end
        rstrb = 1'b0;
    endtask

    int n_busy;
    int cs_hi;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_rbusy", 32'(rbusy), 32'd0);
        check("rst_cs_n", 32'(CS_N), 32'd1);
        check("rst_clk", 32'(CLK), 32'd0);
        check("rst_mosi", 32'(MOSI), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Basic read of word 0
        do_read(20'd0, -1, n_busy);
        check("basic_cmd", cmd_cap, {EXP_OP, 24'h100000});
        check("basic_rdata", rdata, 32'h44332211);
        check("basic_busy", 32'(n_busy), 32'(EXP_LAT));
        check("basic_mosi_low", 32'(extra_nz), 32'd0);
        check("basic_cs_n_hold", 32'(CS_N), 32'd1);

        // Top word of the window
        repeat (2) @(posedge clk); #1;
        do_read(20'hFFFFF, -1, n_busy);
        check("top_cmd", cmd_cap, {EXP_OP, 24'h4FFFFC});
        check("top_rdata", rdata, 32'hD4C3B2A1);

        // Strobe during a transaction must be ignored
        repeat (2) @(posedge clk); #1;
        do_read(20'd1, 40, n_busy);
        check("ign_cmd", cmd_cap, {EXP_OP, 24'h100004});
        check("ign_rdata", rdata, 32'h88776655);
        check("ign_busy", 32'(n_busy), 32'(EXP_LAT));
        repeat (3) @(posedge clk); #1;
        check("ign_no_restart", 32'(CS_N), 32'd1);

        // Back-to-back: strobe in the HOLD cycle
        do_read(20'd0, -1, n_busy);
        check("b2b_first", rdata, 32'h44332211);
        word_address = 20'd1;
        rstrb = 1'b1;
        cs_hi = 0;
        while (CS_N && cs_hi < 10) begin
            cs_hi++;
            @(posedge clk); #1;
            rstrb = 1'b0;
        end
        check("b2b_cs_high", 32'(cs_hi), 32'd2);
        n_busy = 0;
        while (rbusy && n_busy < 1000) begin
            n_busy++;
            @(posedge clk); #1;
        end
        check("b2b_done", 32'(rbusy), 32'd0);
        check("b2b_cmd", cmd_cap, {EXP_OP, 24'h100004});
        check("b2b_rdata", rdata, 32'h88776655);

        // Reset abort in cycle 70 (an SPI-clock high phase)
        repeat (2) @(posedge clk); #1;
        word_address = 20'hFFFFF;
        rstrb = 1'b1;
        @(posedge clk); #1;
        rstrb = 1'b0;
        repeat (69) @(posedge clk);
        #1;
        check("abort_clk_high", 32'(CLK), 32'd1);
        resetn = 1'b0;
        #1;
        check("abort_cs_n", 32'(CS_N), 32'd1);
        check("abort_clk", 32'(CLK), 32'd0);
        check("abort_rbusy", 32'(rbusy), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        do_read(20'd0, -1, n_busy);
        check("after_abort_rdata", rdata, 32'h44332211);
        check("after_abort_busy", 32'(n_busy), 32'(EXP_LAT));

        // Address wrap: offset FFFFFC plus byte 4 wraps to address 0
        word_address2 = 20'd1;
        rstrb2 = 1'b1;
        @(posedge clk); #1;
        rstrb2 = 1'b0;
        n_busy = 0;
        while (rbusy2 && n_busy < 1000) begin
            n_busy++;
            @(posedge clk); #1;
        end
        check("wrap_cmd", cmd_cap2, {EXP_OP, 24'h000000});
        check("wrap_rdata", rdata2, 32'hFFFFFFFF);
        check("wrap_busy", 32'(n_busy), 32'(EXP_LAT));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
